lc3b_mem_arbiter: RTL
=====================

Name: lc3b_mem_arbiter

Overview:
- Memory-side responder for the LC-3b pipeline's two memory initiators: the instruction-fetch side (level mem_request, 1-cycle mem_resp) and the data-access side (MEM stage read/write).
- Serialises both onto one physical memory port and returns a one-cycle resp pulse with registered read data to the granted initiator.
- Sits between the pipeline stage registers and the physical memory model.

Parameters:
- D_STREAK_MAX, 4: max consecutive data grants while an instruction request is pending; the next grant is then forced to the instruction side. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- i_mem_request  input  1  fetch request; held high until i_mem_resp is seen.
- i_mem_address  input  16  fetch word address.
- i_mem_rdata  output  16  fetched instruction; valid while i_mem_resp=1.
- i_mem_resp  output  1  one-cycle completion pulse to the fetch side.
- d_mem_read  input  1  data read request; held until d_mem_resp.
- d_mem_write  input  1  data write request; held until d_mem_resp.
- d_mem_byte_enable  input  2  write byte lanes: [1]=high byte, [0]=low byte.
- d_mem_address  input  16  data address.
- d_mem_wdata  input  16  write data.
- d_mem_rdata  output  16  read data; valid while d_mem_resp=1.
- d_mem_resp  output  1  one-cycle completion pulse to the data side.
- pmem_read  output  1  physical read strobe; held until pmem_resp.
- pmem_write  output  1  physical write strobe; held until pmem_resp.
- pmem_byte_enable  output  2  forwarded byte lanes; 2'b11 on reads.
- pmem_address  output  16  latched address.
- pmem_wdata  output  16  latched write data.
- pmem_rdata  input  16  physical read data; valid with pmem_resp.
- pmem_resp  input  1  physical completion.

Behaviour:
- Reset: all outputs 0, state IDLE, streak counter 0. Reset mid-transaction abandons it with no resp to any initiator. A pmem_resp arriving in IDLE is ignored.
- States: IDLE, I_ACC, D_ACC, I_DONE, D_DONE. All outputs are registered or Moore-decoded from state; no combinational path from any input to any output.
- IDLE, data pending (d_mem_read|d_mem_write):
  - Goes to D_ACC unless an instruction request is also pending and streak==D_STREAK_MAX; in that case goes to I_ACC.
- IDLE, only i_mem_request pending: goes to I_ACC.
- Grant latching, at the IDLE-exit edge: latch address, wdata and byte_enable into the pmem_* registers. Later initiator input changes do not affect the transaction.
- Streak counter:
  - Increments (saturating at D_STREAK_MAX) on a data grant while i_mem_request=1.
  - Clears on any instruction grant, or on a data grant while i_mem_request=0.
- Read/write encoding:
  - d_mem_write=1 selects a write; write wins if d_mem_read is also 1.
  - Reads drive pmem_byte_enable=2'b11.
  - Writes with byte_enable=2'b00 still issue a pmem write and complete normally.
- I_ACC/D_ACC:
  - Hold pmem_read or pmem_write high.
  - On the edge where pmem_resp=1: capture pmem_rdata (reads only), go to I_DONE/D_DONE, drop the strobe.
  - No timeout.
- I_DONE/D_DONE:
  - Assert i_mem_resp or d_mem_resp for exactly one cycle, with rdata held stable; then go to IDLE.
  - rdata registers hold their last value after the pulse; d_mem_rdata is unchanged by writes.
- Request sampling: the initiator deasserts its request on the edge it sees resp, so IDLE samples requests fresh. A request still high in IDLE is treated as a new transaction.
- Latency: request first high in cycle N → strobe in N+1. With pmem_resp in cycle M, resp pulse is in M+1. Minimum request-to-resp is 2 cycles.
- Only one transaction is ever outstanding.

Test Plan:
- Fetch alone: i_mem_request=1, addr 0x0010; pmem returns 0x1234 after 3 cycles → pmem_read with addr 0x0010 from N+1; i_mem_resp one cycle with i_mem_rdata=0x1234; d_mem_resp stays 0.
- Byte write: d_mem_write=1, addr 0x2001, wdata 0xAB00, byte_enable=2'b10 → pmem_write with 2'b10 and 0xAB00; d_mem_resp one pulse; d_mem_rdata unchanged.
- Simultaneous fetch and data read in IDLE → data served first, then the fetch. Both resp pulses are one cycle each and never overlap.
- Starvation: fetch held high, data requests back-to-back, D_STREAK_MAX=4 → 4 data grants, then an instruction grant, then the counter is 0.
- Reset mid-operation: reset during D_ACC, pmem_resp arrives 2 cycles later → no d_mem_resp; all outputs 0; IDLE ignores the stray resp.
- Stability: change d_mem_address mid-D_ACC → pmem_address keeps the latched value.

Source files
------------

// File: rtl/lc3b_mem_arbiter.sv
// Memory-side arbiter for the LC-3b pipeline: serialises the instruction-fetch and
// data-access initiators onto one physical memory port, one transaction at a time.
// Data normally wins ties; a pending fetch is forced through after D_STREAK_MAX
// consecutive data grants.
module lc3b_mem_arbiter #(
  parameter int unsigned D_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // Instruction-fetch initiator
  input  logic        i_mem_request,
  input  logic [15:0] i_mem_address,
  output logic [15:0] i_mem_rdata,
  output logic        i_mem_resp,
  // Data-access initiator
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [1:0]  d_mem_byte_enable,
  input  logic [15:0] d_mem_address,
  input  logic [15:0] d_mem_wdata,
  output logic [15:0] d_mem_rdata,
  output logic        d_mem_resp,
  // Physical memory port
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_byte_enable,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [2:0] {
    StIdle,
    StIAcc,
    StDAcc,
    StIDone,
    StDDone
  } state_e;

  localparam logic [3:0] StreakMax = 4'(D_STREAK_MAX);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic d_pend;
  logic force_i;

  assign d_pend  = d_mem_read | d_mem_write;
  // A waiting fetch that has already sat out a full data streak takes this grant.
  assign force_i = i_mem_request && (streak_q == StreakMax);

  // Next-state: arbitration and request latching in IDLE, completion capture in ACC.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (d_pend && !force_i) begin
          state_d = StDAcc;
          wr_d    = d_mem_write;  // write wins if both strobes are high
          addr_d  = d_mem_address;
          wdata_d = d_mem_wdata;
          be_d    = d_mem_write ? d_mem_byte_enable : 2'b11;
          if (!i_mem_request) begin
            streak_d = 4'd0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (i_mem_request) begin
          state_d  = StIAcc;
          wr_d     = 1'b0;
          addr_d   = i_mem_address;
          wdata_d  = 16'h0000;
          be_d     = 2'b11;
          streak_d = 4'd0;
        end
      end
      StIAcc: begin
        if (pmem_resp) begin
          i_rdata_d = pmem_rdata;
          state_d   = StIDone;
        end
      end
      StDAcc: begin
        if (pmem_resp) begin
          if (!wr_q) begin
            d_rdata_d = pmem_rdata;
          end
          state_d = StDDone;
        end
      end
      StIDone, StDDone: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      streak_q  <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      be_q      <= 2'b00;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Moore outputs: strobes and resp pulses decode from state only.
  always_comb begin
    pmem_read        = (state_q == StIAcc) || ((state_q == StDAcc) && !wr_q);
    pmem_write       = (state_q == StDAcc) && wr_q;
    pmem_byte_enable = be_q;
    pmem_address     = addr_q;
    pmem_wdata       = wdata_q;
    i_mem_resp       = (state_q == StIDone);
    d_mem_resp       = (state_q == StDDone);
    i_mem_rdata      = i_rdata_q;
    d_mem_rdata      = d_rdata_q;
  end

endmodule
